// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-clock SPI master for the spi_wrapper slave frame format.
// It sends one select bit, then a 10-bit command MSB first. For read-data
// commands it then waits and shifts an 8-bit reply in from MISO.
// Optional feature macro: SPI_MASTER_SEQ_CHECK_EN. When it is defined, a
// read-data command that is not preceded by a read-address command is
// rejected with an err pulse instead of being transmitted.
module spi_master_ctrl #(
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] frame,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEL,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_t;

  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RECV_LAST  = 4'd7;
  localparam logic [3:0] WAIT_LAST  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [9:0] frame_reg, frame_next;
  logic [7:0] rx_reg, rx_next;
  logic [7:0] rd_data_reg, rd_data_next;
  logic       ss_n_reg, ss_n_next;
  logic       mosi_reg, mosi_next;
  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       rd_valid_reg, rd_valid_next;
  logic       take;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       err_reg, err_next;
  logic       addr_set_reg, addr_set_next;
`endif

  // State, counters, data registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      frame_reg    <= 10'd0;
      rx_reg       <= 8'd0;
      rd_data_reg  <= 8'd0;
      ss_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      err_reg      <= 1'b0;
      addr_set_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      frame_reg    <= frame_next;
      rx_reg       <= rx_next;
      rd_data_reg  <= rd_data_next;
      ss_n_reg     <= ss_n_next;
      mosi_reg     <= mosi_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      rd_valid_reg <= rd_valid_next;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      err_reg      <= err_next;
      addr_set_reg <= addr_set_next;
`endif
    end
  end

  // Next-state logic: frame acceptance, bit counting, MISO capture, completion pulses.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    frame_next    = frame_reg;
    rx_next       = rx_reg;
    rd_data_next  = rd_data_reg;
    done_next     = 1'b0;
    rd_valid_next = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    err_next      = 1'b0;
    addr_set_next = addr_set_reg;
`endif

    // A request is taken when idle or in the final gap cycle, so that
    // back-to-back frames see exactly GAP_CYCLES of SS_n high.
    take = start && ((state_reg == ST_IDLE) ||
                     ((state_reg == ST_GAP) && (cnt_reg == GAP_LAST)));

    if (take) begin
      frame_next = frame;
      cnt_next   = 4'd0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      if ((frame[9:8] == 2'b11) && !addr_set_reg) begin
        // Read-data without a prior read-address: report and skip the frame.
        state_next = ST_GAP;
        done_next  = 1'b1;
        err_next   = 1'b1;
      end else begin
        state_next = ST_START;
      end
`else
      state_next = ST_START;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end
        ST_START: begin
          state_next = ST_SEL;
        end
        ST_SEL: begin
          state_next = ST_SHIFT;
          cnt_next   = 4'd0;
        end
        ST_SHIFT: begin
          if (cnt_reg == SHIFT_LAST) begin
            cnt_next = 4'd0;
            if (frame_reg[9:8] == 2'b11) begin
              state_next = ST_WAIT;
            end else begin
              state_next = ST_GAP;
              done_next  = 1'b1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
              if (frame_reg[9:8] == 2'b10) begin
                addr_set_next = 1'b1;
              end
`endif
            end
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == WAIT_LAST) begin
            state_next = ST_RECV;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        ST_RECV: begin
          rx_next = {rx_reg[6:0], MISO};
          if (cnt_reg == RECV_LAST) begin
            state_next    = ST_GAP;
            cnt_next      = 4'd0;
            done_next     = 1'b1;
            rd_valid_next = 1'b1;
            rd_data_next  = {rx_reg[6:0], MISO};
`ifdef SPI_MASTER_SEQ_CHECK_EN
            addr_set_next = 1'b0;
`endif
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        ST_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state, so every pin comes straight from a flop.
  always_comb begin
    ss_n_next  = 1'b1;
    mosi_next  = 1'b0;
    busy_next  = (state_next != ST_IDLE);
    ready_next = (state_next == ST_IDLE) ||
                 ((state_next == ST_GAP) && (cnt_next == GAP_LAST));
    case (state_next)
      ST_START: begin
        ss_n_next = 1'b0;
      end
      ST_SEL: begin
        ss_n_next = 1'b0;
        mosi_next = frame_next[9];
      end
      ST_SHIFT: begin
        ss_n_next = 1'b0;
        mosi_next = frame_next[4'd9 - cnt_next];
      end
      ST_WAIT, ST_RECV: begin
        ss_n_next = 1'b0;
      end
      default: begin
        ss_n_next = 1'b1;
      end
    endcase
  end

  assign SS_n     = ss_n_reg;
  assign MOSI     = mosi_reg;
  assign ready    = ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed frames from the plan,
// randomized frames against a cycle-indexed reference of the frame format.
module tb_spi_master_ctrl;

  localparam int RD_LATENCY = 2;
  localparam int GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] frame = 10'd0;
  logic       MISO = 1'b0;
  logic       ready, busy, done, rd_valid, err, SS_n, MOSI;
  logic [7:0] rd_data;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_rd_data = 8'h00;
  bit         addr_set = 1'b0;

  spi_master_ctrl #(.RD_LATENCY(RD_LATENCY), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame(frame),
    .ready(ready), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Expected MOSI at cycle k of the SS_n-low window (k=0 is START).
  function automatic logic exp_mosi(input logic [9:0] f, input int k);
    if (k == 1) return f[9];
    if (k >= 2 && k <= 11) return f[11 - k];
    return 1'b0;
  endfunction

  // Idle cycles with nothing requested.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      MISO = 1'($urandom);
      chk("idle_ss", SS_n, 1);
      chk("idle_mosi", MOSI, 0);
      chk("idle_ready", ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rdv", rd_valid, 0);
    end
  endtask

  // One whole transaction; entered at a negedge where ready must be 1 and
  // returns at the negedge of the final gap cycle, so calls chain back-to-back.
  task automatic do_frame(input logic [9:0] f, input logic [7:0] rx_byte);
    bit is_rd;
    bit skip;
    int n_low;
    int low_seen;
    is_rd = (f[9:8] == 2'b11);
    skip  = 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
    skip = is_rd && !addr_set;
`endif
    n_low = skip ? 0 : (is_rd ? 20 + RD_LATENCY : 12);
    low_seen = 0;
    chk("ready_pre", ready, 1);
    start = 1'b1;
    frame = f;
    MISO  = 1'($urandom);
    for (int k = 0; k < n_low; k++) begin
      @(negedge clk);
      // requests while busy must be dropped
      start = 1'($urandom_range(0, 1));
      frame = 10'($urandom);
      if (SS_n === 1'b0) low_seen++;
      chk("mosi", MOSI, exp_mosi(f, k));
      chk("busy", busy, 1);
      chk("ready_mid", ready, 0);
      chk("done_mid", done, 0);
      if (is_rd && k >= 12 + RD_LATENCY)
        MISO = rx_byte[7 - (k - 12 - RD_LATENCY)];
      else
        MISO = 1'($urandom);
    end
    chk("ss_low_len", low_seen, n_low);
    // completion cycle
    @(negedge clk);
    start = 1'b0;
    MISO  = 1'($urandom);
    if (is_rd && !skip) exp_rd_data = rx_byte;
    if (f[9:8] == 2'b10) addr_set = 1'b1;
    if (is_rd && !skip) addr_set = 1'b0;
    chk("end_ss", SS_n, 1);
    chk("end_mosi", MOSI, 0);
    chk("end_done", done, 1);
    chk("end_rdv", rd_valid, is_rd && !skip);
    chk("end_err", err, skip);
    chk("end_rd_data", rd_data, exp_rd_data);
    chk("end_ready", ready, GAP_CYCLES == 1);
    chk("end_busy", busy, 1);
    for (int g = 1; g < GAP_CYCLES; g++) begin
      @(negedge clk);
      chk("gap_ss", SS_n, 1);
      chk("gap_done", done, 0);
      chk("gap_ready", ready, g == GAP_CYCLES - 1);
    end
    $display("txn frame=%03h type=%0d miso=%02h rd_data=%02h skip=%0d", f, f[9:8], rx_byte, rd_data, skip);
  endtask

  initial begin
    logic [9:0] rf;
    logic [7:0] rb;
    // reset held three cycles with noise on the inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      frame = 10'($urandom);
      chk("rst_ss", SS_n, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_err", err, 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    idle(2);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    // read-data with no address set is rejected
    do_frame(10'b11_0000_0000, 8'hA5);
    idle(1);
`endif
    // write address
    do_frame(10'b00_0000_0101, 8'h00);
    idle(2);
    // write data then read address back-to-back
    do_frame({2'b01, 8'h25}, 8'h00);
    do_frame({2'b10, 8'h05}, 8'h00);
    idle(1);
    // read data
    do_frame(10'b11_0000_0000, 8'h25);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rf = 10'($urandom);
      rb = 8'($urandom);
      do_frame(rf, rb);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    // abort during SHIFT bit 4 (cycle 6 of the low window)
    start = 1'b1;
    frame = {2'b01, 8'hC3};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort_ss", SS_n, 0);
      if (k == 6) rst_n = 1'b0;
    end
    @(negedge clk);
    exp_rd_data = 8'h00;
    addr_set = 1'b0;
    chk("abort_ss_hi", SS_n, 1);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 1);
    chk("abort_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    idle(3);
    do_frame({2'b10, 8'h3C}, 8'h00);
    idle(1);
    do_frame({2'b11, 8'h00}, 8'h9B);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
